// File: rtl/fetch_queue.sv
// fetch_queue: epoch-tagged circular instruction buffer between imem responses and decode.
// Optional FETCH_QUEUE_BYPASS_EN: an empty queue forwards an accepted response to decode in the same cycle.
module fetch_queue #(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   output logic             epoch,
   input  logic             enq_valid,
   input  logic             enq_epoch,
   input  logic [31:0]      enq_pc,
   input  logic [31:0]      enq_instr,
   output logic             enq_ready,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [31:0]      deq_pc,
   output logic [31:0]      deq_instr,
   output logic [6:0]       deq_opcode,
   output logic [2:0]       deq_funct3,
   output logic [6:0]       deq_funct7,
   output logic [4:0]       deq_rs2_idx,
   output logic [PTR_W:0]   fq_count
);
   logic [31:0]      pc_mem [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic             enq_ok, byp, deq_fire, wr_en, rd_en;
   assign enq_ready = fq_count != (PTR_W+1)'(DEPTH);
   assign enq_ok    = enq_valid & enq_ready & (enq_epoch == epoch) & ~flush;
`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = enq_ok & (fq_count == '0);
`else
   assign byp = 1'b0;
`endif
   assign deq_valid   = ((fq_count != '0) | byp) & ~flush;
   assign deq_pc      = byp ? enq_pc : pc_mem[rd_ptr];
   assign deq_instr   = byp ? enq_instr : instr_mem[rd_ptr];
   assign deq_opcode  = deq_instr[6:0];
   assign deq_funct3  = deq_instr[14:12];
   assign deq_funct7  = deq_instr[31:25];
   assign deq_rs2_idx = deq_instr[24:20];
   assign deq_fire    = deq_valid & deq_ready & ~flush;
   // a bypassed entry consumed in the same cycle never touches storage
   assign wr_en = enq_ok & ~(byp & deq_ready);
   assign rd_en = deq_fire & ~byp;
   // pointers, occupancy and epoch; flush empties the queue and opens a new epoch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fq_count <= '0;
         epoch    <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fq_count <= '0;
         epoch    <= ~epoch;
      end else begin
         fq_count <= fq_count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end
   // entry storage; cleared only by reset, flush leaves stale data behind
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (wr_en) begin
         pc_mem[wr_ptr]    <= enq_pc;
         instr_mem[wr_ptr] <= enq_instr;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (default or FETCH_QUEUE_BYPASS_EN build).
module tb_fetch_queue;
   logic        clk = 0, rst = 1, flush = 0, enq_valid = 0, enq_epoch = 0, deq_ready = 0;
   logic [31:0] enq_pc = 0, enq_instr = 0;
   logic        epoch, enq_ready, deq_valid;
   logic [31:0] deq_pc, deq_instr;
   logic [6:0]  deq_opcode, deq_funct7;
   logic [2:0]  deq_funct3;
   logic [4:0]  deq_rs2_idx;
   logic [2:0]  fq_count;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   int          tests = 0, fails = 0, m_cnt = 0;
   logic        m_epoch = 0;
   logic [31:0] q_pc[$], q_instr[$];

   fetch_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .epoch(epoch),
      .enq_valid(enq_valid), .enq_epoch(enq_epoch), .enq_pc(enq_pc), .enq_instr(enq_instr),
      .enq_ready(enq_ready), .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_pc(deq_pc), .deq_instr(deq_instr), .deq_opcode(deq_opcode), .deq_funct3(deq_funct3),
      .deq_funct7(deq_funct7), .deq_rs2_idx(deq_rs2_idx), .fq_count(fq_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic drive(input logic ev, input logic ep, input logic [31:0] pc, input logic [31:0] ins,
                        input logic dr, input logic fl);
      enq_valid = ev; enq_epoch = ep; enq_pc = pc; enq_instr = ins; deq_ready = dr; flush = fl;
   endtask

   // one clock: compare outputs with the model, update scoreboard, advance past the edge
   task automatic cyc();
      bit acc, byp, dv;
      #1;
      acc = enq_valid && m_cnt != 4 && enq_epoch == m_epoch && !flush;
      byp = BYP && acc && m_cnt == 0;
      dv  = (m_cnt != 0 || byp) && !flush;
      tests++; if (fq_count !== 3'(m_cnt)) begin fails++; $display("FAIL count: got %0d want %0d", fq_count, m_cnt); end
      tests++; if (enq_ready !== (m_cnt != 4)) begin fails++; $display("FAIL enq_ready: got %b want %b", enq_ready, m_cnt != 4); end
      tests++; if (epoch !== m_epoch) begin fails++; $display("FAIL epoch: got %b want %b", epoch, m_epoch); end
      tests++; if (deq_valid !== dv) begin fails++; $display("FAIL deq_valid: got %b want %b", deq_valid, dv); end
      if (acc) begin q_pc.push_back(enq_pc); q_instr.push_back(enq_instr); end
      if (dv) begin
         tests++;
         if (q_pc.size() == 0) begin fails++; $display("FAIL scoreboard: deq expected but queue model empty"); end
         else begin
            if ({deq_pc, deq_instr} !== {q_pc[0], q_instr[0]}) begin
               fails++; $display("FAIL head: got pc=%h instr=%h want pc=%h instr=%h", deq_pc, deq_instr, q_pc[0], q_instr[0]);
            end
            tests++;
            if ({deq_opcode, deq_funct3, deq_funct7, deq_rs2_idx} !==
                {q_instr[0][6:0], q_instr[0][14:12], q_instr[0][31:25], q_instr[0][24:20]}) begin
               fails++; $display("FAIL fields: got op=%h f3=%h f7=%h rs2=%h for instr %h", deq_opcode, deq_funct3, deq_funct7, deq_rs2_idx, q_instr[0]);
            end
            if (deq_ready) begin void'(q_pc.pop_front()); void'(q_instr.pop_front()); end
         end
      end
      if (flush) begin q_pc.delete(); q_instr.delete(); m_epoch = ~m_epoch; end
      m_cnt = q_pc.size();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      tests++; if ({deq_valid, enq_ready, epoch, fq_count} !== 6'b010000) begin fails++; $display("FAIL reset_ctrl: got v=%b r=%b e=%b c=%0d", deq_valid, enq_ready, epoch, fq_count); end
      tests++; if ({deq_pc, deq_instr} !== 64'd0) begin fails++; $display("FAIL reset_data: got pc=%h instr=%h want 0", deq_pc, deq_instr); end
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      drive(1, m_epoch, 32'h60000000, 32'h00A00093, 0, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); #1;
      tests++; if (deq_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", deq_valid); end
      tests++; if (deq_opcode !== 7'h13 || deq_funct3 !== 3'd0) begin fails++; $display("FAIL single_fields: got op=%h f3=%h want 13/0", deq_opcode, deq_funct3); end
      tests++; if (fq_count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", fq_count); end
      cyc();
      drive(0, 0, 0, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); cyc();
   endtask

   task automatic test_full_drain();
      for (int i = 0; i < 4; i++) begin
         drive(1, m_epoch, 32'h100 + 32'(4 * i), $urandom, 0, 0); cyc();
      end
      drive(0, 0, 0, 0, 0, 0); #1;
      tests++; if (enq_ready !== 1'b0 || fq_count !== 3'd4) begin fails++; $display("FAIL full: got ready=%b count=%0d want 0/4", enq_ready, fq_count); end
      drive(1, m_epoch, 32'h200, $urandom, 1, 0); cyc();
      drive(0, 0, 0, 0, 1, 0); #1;
      tests++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL ready_rise: got %b want 1", enq_ready); end
      for (int i = 0; i < 4; i++) cyc();
   endtask

   task automatic test_flush();
      drive(1, m_epoch, 32'h300, $urandom, 0, 0); cyc();
      drive(1, m_epoch, 32'h304, $urandom, 0, 0); cyc();
      drive(1, m_epoch, 32'h308, $urandom, 1, 1); cyc();
      drive(0, 0, 0, 0, 0, 0); #1;
      tests++; if (fq_count !== 3'd0 || deq_valid !== 1'b0 || epoch !== 1'b1) begin fails++; $display("FAIL flush: got count=%0d v=%b epoch=%b want 0/0/1", fq_count, deq_valid, epoch); end
      drive(1, 0, 32'h400, $urandom, 0, 0); cyc();
      drive(1, 1, 32'h404, 32'h00B00113, 0, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); #1;
      tests++; if (fq_count !== 3'd1 || deq_pc !== 32'h404) begin fails++; $display("FAIL epoch_accept: got count=%0d pc=%h want 1/404", fq_count, deq_pc); end
      drive(0, 0, 0, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); cyc();
   endtask

   task automatic test_stream();
      drive(1, m_epoch, 32'h500, $urandom, 0, 0); cyc();
      for (int i = 0; i < 20; i++) begin
         drive(1, m_epoch, 32'h504 + 32'(4 * i), $urandom, 1, 0); cyc();
         tests++; if (fq_count !== 3'd1) begin fails++; $display("FAIL stream_count: cycle %0d got %0d want 1", i, fq_count); end
      end
      drive(0, 0, 0, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); cyc();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, m_epoch, 32'h600 + 32'(4 * i), $urandom, 0, 0); cyc();
      end
      drive(0, 0, 0, 0, 0, 0);
      #2 rst = 1;
      #1;
      tests++; if ({deq_valid, enq_ready, epoch, fq_count} !== 6'b010000) begin fails++; $display("FAIL async_ctrl: got v=%b r=%b e=%b c=%0d", deq_valid, enq_ready, epoch, fq_count); end
      tests++; if ({deq_pc, deq_instr} !== 64'd0) begin fails++; $display("FAIL async_data: got pc=%h instr=%h want 0", deq_pc, deq_instr); end
      q_pc.delete(); q_instr.delete(); m_cnt = 0; m_epoch = 0;
      @(negedge clk) rst = 0;
      @(posedge clk); #1;
      cyc();
   endtask

   task automatic test_bypass();
      drive(1, m_epoch, 32'h700, 32'h00000033, 1, 0); #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      tests++; if (deq_valid !== 1'b1 || deq_opcode !== 7'h33) begin fails++; $display("FAIL bypass: got v=%b op=%h want 1/33", deq_valid, deq_opcode); end
`else
      tests++; if (deq_valid !== 1'b0) begin fails++; $display("FAIL no_bypass: got v=%b want 0", deq_valid); end
`endif
      cyc();
      drive(0, 0, 0, 0, 0, 0); #1;
      tests++; if (fq_count !== (BYP ? 3'd0 : 3'd1)) begin fails++; $display("FAIL bypass_count: got %0d want %0d", fq_count, BYP ? 0 : 1); end
      drive(0, 0, 0, 0, 1, 0); cyc();
      drive(0, 0, 0, 0, 0, 0); cyc();
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_drain();
      test_flush();
      test_stream();
      test_async_reset();
      test_bypass();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
